multicycle_control: RTL and testbench



---
 rtl/control_pkg.sv | 65 ++++++
 rtl/multicycle_control_if.sv | 31 +++
 rtl/alu_decoder.sv | 32 +++
 rtl/multicycle_control.sv | 178 +++++++++++++++++
 tb/tb_multicycle_control.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/control_pkg.sv
// Shared encodings for the multicycle RV32I control FSM and its ALU decoder.
package control_pkg;

   localparam int unsigned OP_W    = 7;
   localparam int unsigned SEL_W   = 2;
   localparam int unsigned ALUC_W  = 3;
   localparam int unsigned F3_W    = 3;
   localparam int unsigned INSTR_W = 32;

   typedef enum logic [3:0] {
      FETCH,
      DECODE,
      MEMADR,
      MEMREAD,
      MEMWB,
      MEMWRITE,
      EXECR,
      EXECI,
      ALUWB,
      BRANCH,
      JAL
   } state_t;

   // immediate format for the sign-extension unit
   localparam logic [SEL_W-1:0] IMM_I = 2'b00;
   localparam logic [SEL_W-1:0] IMM_S = 2'b01;
   localparam logic [SEL_W-1:0] IMM_B = 2'b10;
   localparam logic [SEL_W-1:0] IMM_J = 2'b11;

   // ALU operations
   localparam logic [ALUC_W-1:0] ALU_ADD = 3'b000;
   localparam logic [ALUC_W-1:0] ALU_SUB = 3'b001;
   localparam logic [ALUC_W-1:0] ALU_AND = 3'b010;
   localparam logic [ALUC_W-1:0] ALU_OR  = 3'b011;
   localparam logic [ALUC_W-1:0] ALU_SLT = 3'b101;

   // coarse ALU request from the FSM to the decoder
   localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'b00;
   localparam logic [SEL_W-1:0] ALUOP_SUB   = 2'b01;
   localparam logic [SEL_W-1:0] ALUOP_FUNCT = 2'b10;

   // result mux
   localparam logic [SEL_W-1:0] RES_ALUOUT = 2'b00;
   localparam logic [SEL_W-1:0] RES_RDATA  = 2'b01;
   localparam logic [SEL_W-1:0] RES_ALU    = 2'b10;

   // ALU source A
   localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
   localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
   localparam logic [SEL_W-1:0] SRCA_RS1   = 2'b10;

   // ALU source B
   localparam logic [SEL_W-1:0] SRCB_RS2  = 2'b00;
   localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
   localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

   // opcodes
   localparam logic [OP_W-1:0] OP_LW     = 7'b0000011;
   localparam logic [OP_W-1:0] OP_SW     = 7'b0100011;
   localparam logic [OP_W-1:0] OP_R      = 7'b0110011;
   localparam logic [OP_W-1:0] OP_I      = 7'b0010011;
   localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
   localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;

endpackage

// File: rtl/multicycle_control_if.sv
// Control/datapath boundary: instruction and status in, enables and selects out.
interface multicycle_control_if;
   import control_pkg::*;

   logic [INSTR_W-1:0] instr_i;
   logic               zero_i;
   logic               mem_ready_i;
   logic               pcwrite_o;
   logic               adrsrc_o;
   logic               memwrite_o;
   logic               irwrite_o;
   logic               regwrite_o;
   logic [SEL_W-1:0]   resultsrc_o;
   logic [SEL_W-1:0]   alusrca_o;
   logic [SEL_W-1:0]   alusrcb_o;
   logic [ALUC_W-1:0]  alucontrol_o;
   logic [SEL_W-1:0]   immsrc_o;
   logic               illegal_o;

   modport master (
      input  instr_i, zero_i, mem_ready_i,
      output pcwrite_o, adrsrc_o, memwrite_o, irwrite_o, regwrite_o,
             resultsrc_o, alusrca_o, alusrcb_o, alucontrol_o, immsrc_o, illegal_o
   );

   modport slave (
      output instr_i, zero_i, mem_ready_i,
      input  pcwrite_o, adrsrc_o, memwrite_o, irwrite_o, regwrite_o,
             resultsrc_o, alusrca_o, alusrcb_o, alucontrol_o, immsrc_o, illegal_o
   );
endinterface

// File: rtl/alu_decoder.sv
// Maps the FSM's coarse ALU request plus funct fields onto an ALU operation.
module alu_decoder
   import control_pkg::*;
(
   input  logic [SEL_W-1:0]  aluop,
   input  logic [F3_W-1:0]   funct3,
   input  logic              funct7b5,
   input  logic              op5,
   output logic [ALUC_W-1:0] alucontrol,
   output logic              illegal
);

   // funct decode; op5 separates R-type (sub possible) from I-type (addi only)
   always_comb begin
      alucontrol = ALU_ADD;
      illegal    = 1'b0;
      case (aluop)
         ALUOP_SUB: alucontrol = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               3'b000:  alucontrol = (funct7b5 && op5) ? ALU_SUB : ALU_ADD;
               3'b010:  alucontrol = ALU_SLT;
               3'b110:  alucontrol = ALU_OR;
               3'b111:  alucontrol = ALU_AND;
               default: illegal    = 1'b1;
            endcase
         end
         default: alucontrol = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle RV32I datapath.
module multicycle_control
   import control_pkg::*;
#(
   parameter state_t RESET_STATE = FETCH
)(
   input  logic                 clk_i,
   input  logic                 rst_ni,
   multicycle_control_if.master bus
);

   state_t             state_q, state_d;
   logic [OP_W-1:0]    op;
   logic [F3_W-1:0]    funct3;
   logic               funct7b5;
   logic [SEL_W-1:0]   aluop;
   logic [ALUC_W-1:0]  alucontrol;
   logic               alu_illegal;
   logic               dec_illegal;
   logic               pcwrite, adrsrc, memwrite, irwrite, regwrite;
   logic [SEL_W-1:0]   resultsrc, alusrca, alusrcb, immsrc;
   logic               unused_instr;

   assign op           = bus.instr_i[6:0];
   assign funct3       = bus.instr_i[14:12];
   assign funct7b5     = bus.instr_i[30];
   assign unused_instr = ^{bus.instr_i[31], bus.instr_i[29:15], bus.instr_i[11:7]};

   // state register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= RESET_STATE;
      else         state_q <= state_d;
   end

   // ALU request per state, kept apart so the decoder's illegal flag can steer next state
   always_comb begin
      aluop = ALUOP_ADD;
      case (state_q)
         EXECR, EXECI: aluop = ALUOP_FUNCT;
         BRANCH:       aluop = ALUOP_SUB;
         default:      aluop = ALUOP_ADD;
      endcase
   end

   alu_decoder u_alu_decoder (
      .aluop      (aluop),
      .funct3     (funct3),
      .funct7b5   (funct7b5),
      .op5        (op[5]),
      .alucontrol (alucontrol),
      .illegal    (alu_illegal)
   );

   // next state and control outputs
   always_comb begin
      state_d     = state_q;
      pcwrite     = 1'b0;
      adrsrc      = 1'b0;
      memwrite    = 1'b0;
      irwrite     = 1'b0;
      regwrite    = 1'b0;
      resultsrc   = RES_ALU;
      alusrca     = SRCA_PC;
      alusrcb     = SRCB_FOUR;
      immsrc      = IMM_I;
      dec_illegal = 1'b0;
      case (state_q)
         FETCH: begin
            irwrite = bus.mem_ready_i;
            pcwrite = bus.mem_ready_i;
            if (bus.mem_ready_i) state_d = DECODE;
         end
         DECODE: begin
            alusrca = SRCA_OLDPC;
            alusrcb = SRCB_IMM;
            case (op)
               OP_LW: state_d = MEMADR;
               OP_SW: begin
                  immsrc  = IMM_S;
                  state_d = MEMADR;
               end
               OP_R:  state_d = EXECR;
               OP_I:  state_d = EXECI;
               OP_BRANCH: begin
                  immsrc = IMM_B;
                  if (funct3 == 3'b000 || funct3 == 3'b001) begin
                     state_d = BRANCH;
                  end else begin
                     dec_illegal = 1'b1;
                     state_d     = FETCH;
                  end
               end
               OP_JAL: begin
                  immsrc  = IMM_J;
                  state_d = JAL;
               end
               default: begin
                  dec_illegal = 1'b1;
                  state_d     = FETCH;
               end
            endcase
         end
         MEMADR: begin
            alusrca = SRCA_RS1;
            alusrcb = SRCB_IMM;
            // op[5] distinguishes sw from lw
            if (op[5]) begin
               immsrc  = IMM_S;
               state_d = MEMWRITE;
            end else begin
               state_d = MEMREAD;
            end
         end
         MEMREAD: begin
            resultsrc = RES_ALUOUT;
            adrsrc    = 1'b1;
            if (bus.mem_ready_i) state_d = MEMWB;
         end
         MEMWB: begin
            resultsrc = RES_RDATA;
            regwrite  = 1'b1;
            state_d   = FETCH;
         end
         MEMWRITE: begin
            resultsrc = RES_ALUOUT;
            adrsrc    = 1'b1;
            memwrite  = 1'b1;
            if (bus.mem_ready_i) state_d = FETCH;
         end
         EXECR: begin
            alusrca = SRCA_RS1;
            alusrcb = SRCB_RS2;
            state_d = alu_illegal ? FETCH : ALUWB;
         end
         EXECI: begin
            alusrca = SRCA_RS1;
            alusrcb = SRCB_IMM;
            state_d = alu_illegal ? FETCH : ALUWB;
         end
         ALUWB: begin
            resultsrc = RES_ALUOUT;
            regwrite  = 1'b1;
            state_d   = FETCH;
         end
         BRANCH: begin
            alusrca   = SRCA_RS1;
            alusrcb   = SRCB_RS2;
            resultsrc = RES_ALUOUT;
            immsrc    = IMM_B;
            pcwrite   = bus.zero_i ^ funct3[0];
            state_d   = FETCH;
         end
         JAL: begin
            alusrca   = SRCA_OLDPC;
            alusrcb   = SRCB_FOUR;
            resultsrc = RES_ALUOUT;
            pcwrite   = 1'b1;
            immsrc    = IMM_J;
            state_d   = ALUWB;
         end
         default: state_d = FETCH;
      endcase
   end

   // enables are held low for as long as reset is asserted
   assign bus.pcwrite_o    = rst_ni & pcwrite;
   assign bus.irwrite_o    = rst_ni & irwrite;
   assign bus.memwrite_o   = rst_ni & memwrite;
   assign bus.regwrite_o   = rst_ni & regwrite;
   assign bus.illegal_o    = rst_ni & (dec_illegal | alu_illegal);
   assign bus.adrsrc_o     = adrsrc;
   assign bus.resultsrc_o  = resultsrc;
   assign bus.alusrca_o    = alusrca;
   assign bus.alusrcb_o    = alusrcb;
   assign bus.alucontrol_o = alucontrol;
   assign bus.immsrc_o     = immsrc;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control.
module tb_multicycle_control;

   logic clk;
   logic rst_n;
   int   ncmp;
   int   nerr;

   multicycle_control_if bus ();

   multicycle_control dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // {pcw, adr, mw, irw, rw, rs[1:0], sa[1:0], sb[1:0], ac[2:0], imm[1:0], ill}
   logic [16:0] obs;
   assign obs = {bus.pcwrite_o, bus.adrsrc_o, bus.memwrite_o, bus.irwrite_o, bus.regwrite_o,
                 bus.resultsrc_o, bus.alusrca_o, bus.alusrcb_o, bus.alucontrol_o,
                 bus.immsrc_o, bus.illegal_o};

   function automatic logic [16:0] mk(input logic pcw, input logic adr, input logic mw,
                                      input logic irw, input logic rw, input logic [1:0] rs,
                                      input logic [1:0] sa, input logic [1:0] sb,
                                      input logic [2:0] ac, input logic [1:0] imm,
                                      input logic ill);
      return {pcw, adr, mw, irw, rw, rs, sa, sb, ac, imm, ill};
   endfunction

   logic [16:0] f_idle, f_rdy, aluwb;

   task automatic test_reset();
      rst_n = 1'b0;
      bus.mem_ready_i = 1'b1;
      @(negedge clk);
      #1; ncmp++;
      if (obs !== f_idle) begin nerr++; $display("FAIL reset_hold got %h want %h", obs, f_idle); end
      rst_n = 1'b1;
      bus.mem_ready_i = 1'b0;
      #1; ncmp++;
      if (obs !== f_idle) begin nerr++; $display("FAIL reset_release got %h want %h", obs, f_idle); end
      @(negedge clk);
      #1; ncmp++;
      if (obs !== f_idle) begin nerr++; $display("FAIL reset_fetch_wait got %h want %h", obs, f_idle); end
      bus.mem_ready_i = 1'b1;
      #1; ncmp++;
      if (obs !== f_rdy) begin nerr++; $display("FAIL reset_fetch_ready got %h want %h", obs, f_rdy); end
      bus.mem_ready_i = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_lw();
      logic [16:0] e [8];
      logic        r [8];
      bus.instr_i = 32'h0000_2083;
      bus.zero_i  = 1'b0;
      e[0] = f_idle;                              r[0] = 1'b0;
      e[1] = f_rdy;                               r[1] = 1'b1;
      e[2] = mk(0,0,0,0,0,2'd2,2'd1,2'd1,3'd0,2'd0,0); r[2] = 1'b1;
      e[3] = mk(0,0,0,0,0,2'd2,2'd2,2'd1,3'd0,2'd0,0); r[3] = 1'b1;
      e[4] = mk(0,1,0,0,0,2'd0,2'd0,2'd2,3'd0,2'd0,0); r[4] = 1'b0;
      e[5] = mk(0,1,0,0,0,2'd0,2'd0,2'd2,3'd0,2'd0,0); r[5] = 1'b1;
      e[6] = mk(0,0,0,0,1,2'd1,2'd0,2'd2,3'd0,2'd0,0); r[6] = 1'b1;
      e[7] = f_idle;                              r[7] = 1'b0;
      for (int i = 0; i < 8; i++) begin
         bus.mem_ready_i = r[i];
         #1; ncmp++;
         if (obs !== e[i]) begin nerr++; $display("FAIL lw cyc%0d got %h want %h", i, obs, e[i]); end
         @(negedge clk);
      end
   endtask

   task automatic test_sw();
      logic [16:0] e [7];
      logic        r [7];
      bus.instr_i = 32'h0011_2223;
      e[0] = f_rdy;                               r[0] = 1'b1;
      e[1] = mk(0,0,0,0,0,2'd2,2'd1,2'd1,3'd0,2'd1,0); r[1] = 1'b1;
      e[2] = mk(0,0,0,0,0,2'd2,2'd2,2'd1,3'd0,2'd1,0); r[2] = 1'b1;
      e[3] = mk(0,1,1,0,0,2'd0,2'd0,2'd2,3'd0,2'd0,0); r[3] = 1'b0;
      e[4] = e[3];                                r[4] = 1'b0;
      e[5] = e[3];                                r[5] = 1'b1;
      e[6] = f_idle;                              r[6] = 1'b0;
      for (int i = 0; i < 7; i++) begin
         bus.mem_ready_i = r[i];
         #1; ncmp++;
         if (obs !== e[i]) begin nerr++; $display("FAIL sw cyc%0d got %h want %h", i, obs, e[i]); end
         @(negedge clk);
      end
   endtask

   task automatic test_branch();
      logic [16:0] e [4];
      logic [16:0] dec_b, br_t, br_n;
      logic [31:0] ins [2];
      dec_b = mk(0,0,0,0,0,2'd2,2'd1,2'd1,3'd0,2'd2,0);
      br_t  = mk(1,0,0,0,0,2'd0,2'd2,2'd0,3'd1,2'd2,0);
      br_n  = mk(0,0,0,0,0,2'd0,2'd2,2'd0,3'd1,2'd2,0);
      ins[0] = 32'h0020_8463;
      ins[1] = 32'h0020_9463;
      bus.zero_i = 1'b1;
      // beq taken, bne not taken, both with zero=1
      for (int k = 0; k < 2; k++) begin
         bus.instr_i = ins[k];
         e[0] = f_rdy; e[1] = dec_b; e[2] = (k == 0) ? br_t : br_n; e[3] = f_idle;
         for (int i = 0; i < 4; i++) begin
            bus.mem_ready_i = (i < 3);
            #1; ncmp++;
            if (obs !== e[i]) begin nerr++; $display("FAIL branch%0d cyc%0d got %h want %h", k, i, obs, e[i]); end
            @(negedge clk);
         end
      end
      // bne: pcwrite follows zero_i combinationally within BRANCH
      bus.instr_i = 32'h0020_9463;
      bus.mem_ready_i = 1'b1;
      @(negedge clk);
      @(negedge clk);
      bus.zero_i = 1'b0;
      #1; ncmp++;
      if (obs !== br_t) begin nerr++; $display("FAIL bne_zero0 got %h want %h", obs, br_t); end
      bus.zero_i = 1'b1;
      #1; ncmp++;
      if (obs !== br_n) begin nerr++; $display("FAIL bne_zero1 got %h want %h", obs, br_n); end
      bus.mem_ready_i = 1'b0;
      @(negedge clk);
      // unsupported branch funct3 is flagged in DECODE
      bus.instr_i = 32'h0020_A463;
      e[0] = f_rdy; e[1] = mk(0,0,0,0,0,2'd2,2'd1,2'd1,3'd0,2'd2,1); e[2] = f_idle;
      for (int i = 0; i < 3; i++) begin
         bus.mem_ready_i = (i < 2);
         #1; ncmp++;
         if (obs !== e[i]) begin nerr++; $display("FAIL branch_bad cyc%0d got %h want %h", i, obs, e[i]); end
         @(negedge clk);
      end
   endtask

   task automatic test_alu();
      logic [31:0] ins [5];
      logic [16:0] ex [5];
      logic        ok [5];
      logic [16:0] e [5];
      int          n;
      ins[0] = 32'h4020_8033; ex[0] = mk(0,0,0,0,0,2'd2,2'd2,2'd0,3'd1,2'd0,0); ok[0] = 1'b1;
      ins[1] = 32'h0020_A033; ex[1] = mk(0,0,0,0,0,2'd2,2'd2,2'd0,3'd5,2'd0,0); ok[1] = 1'b1;
      ins[2] = 32'h0020_9033; ex[2] = mk(0,0,0,0,0,2'd2,2'd2,2'd0,3'd0,2'd0,1); ok[2] = 1'b0;
      ins[3] = 32'h4000_0093; ex[3] = mk(0,0,0,0,0,2'd2,2'd2,2'd1,3'd0,2'd0,0); ok[3] = 1'b1;
      ins[4] = 32'h0020_F033; ex[4] = mk(0,0,0,0,0,2'd2,2'd2,2'd0,3'd2,2'd0,0); ok[4] = 1'b1;
      for (int k = 0; k < 5; k++) begin
         bus.instr_i = ins[k];
         e[0] = f_rdy;
         e[1] = mk(0,0,0,0,0,2'd2,2'd1,2'd1,3'd0,2'd0,0);
         e[2] = ex[k];
         e[3] = ok[k] ? aluwb : f_idle;
         e[4] = f_idle;
         n = ok[k] ? 5 : 4;
         for (int i = 0; i < n; i++) begin
            bus.mem_ready_i = (i < n - 1);
            #1; ncmp++;
            if (obs !== e[i]) begin nerr++; $display("FAIL alu%0d cyc%0d got %h want %h", k, i, obs, e[i]); end
            @(negedge clk);
         end
      end
   endtask

   task automatic test_jal_illegal();
      logic [16:0] e [5];
      bus.instr_i = 32'h0080_00EF;
      e[0] = f_rdy;
      e[1] = mk(0,0,0,0,0,2'd2,2'd1,2'd1,3'd0,2'd3,0);
      e[2] = mk(1,0,0,0,0,2'd0,2'd1,2'd2,3'd0,2'd3,0);
      e[3] = aluwb;
      e[4] = f_idle;
      for (int i = 0; i < 5; i++) begin
         bus.mem_ready_i = (i < 4);
         #1; ncmp++;
         if (obs !== e[i]) begin nerr++; $display("FAIL jal cyc%0d got %h want %h", i, obs, e[i]); end
         @(negedge clk);
      end
      bus.instr_i = 32'h0000_007F;
      e[0] = f_rdy;
      e[1] = mk(0,0,0,0,0,2'd2,2'd1,2'd1,3'd0,2'd0,1);
      e[2] = f_idle;
      e[3] = f_idle;
      for (int i = 0; i < 4; i++) begin
         bus.mem_ready_i = (i < 2);
         #1; ncmp++;
         if (obs !== e[i]) begin nerr++; $display("FAIL illegal_op cyc%0d got %h want %h", i, obs, e[i]); end
         @(negedge clk);
      end
   endtask

   task automatic test_reset_mid();
      logic [16:0] e [3];
      logic [16:0] mw;
      bus.instr_i = 32'h0011_2223;
      e[0] = f_rdy;
      e[1] = mk(0,0,0,0,0,2'd2,2'd1,2'd1,3'd0,2'd1,0);
      e[2] = mk(0,0,0,0,0,2'd2,2'd2,2'd1,3'd0,2'd1,0);
      mw   = mk(0,1,1,0,0,2'd0,2'd0,2'd2,3'd0,2'd0,0);
      for (int i = 0; i < 3; i++) begin
         bus.mem_ready_i = 1'b1;
         #1; ncmp++;
         if (obs !== e[i]) begin nerr++; $display("FAIL rstmid cyc%0d got %h want %h", i, obs, e[i]); end
         @(negedge clk);
      end
      bus.mem_ready_i = 1'b0;
      #1; ncmp++;
      if (obs !== mw) begin nerr++; $display("FAIL rstmid_memwrite got %h want %h", obs, mw); end
      #1 rst_n = 1'b0;
      #1; ncmp++;
      if (obs !== f_idle) begin nerr++; $display("FAIL rstmid_async got %h want %h", obs, f_idle); end
      bus.mem_ready_i = 1'b1;
      #1; ncmp++;
      if (obs !== f_idle) begin nerr++; $display("FAIL rstmid_ready_in_reset got %h want %h", obs, f_idle); end
      @(negedge clk);
      rst_n = 1'b1;
      bus.mem_ready_i = 1'b0;
      @(negedge clk);
      #1; ncmp++;
      if (obs !== f_idle) begin nerr++; $display("FAIL rstmid_after got %h want %h", obs, f_idle); end
      bus.mem_ready_i = 1'b1;
      #1; ncmp++;
      if (obs !== f_rdy) begin nerr++; $display("FAIL rstmid_fetch_ready got %h want %h", obs, f_rdy); end
      bus.mem_ready_i = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      ncmp = 0;
      nerr = 0;
      rst_n = 1'b0;
      bus.instr_i = 32'h0000_0013;
      bus.zero_i = 1'b0;
      bus.mem_ready_i = 1'b0;
      f_idle = mk(0,0,0,0,0,2'd2,2'd0,2'd2,3'd0,2'd0,0);
      f_rdy  = mk(1,0,0,1,0,2'd2,2'd0,2'd2,3'd0,2'd0,0);
      aluwb  = mk(0,0,0,0,1,2'd0,2'd0,2'd2,3'd0,2'd0,0);
      test_reset();
      test_lw();
      test_sw();
      test_branch();
      test_alu();
      test_jal_illegal();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
